// File: rtl/mcycle_exec_ctl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-timeout recovery.
// Optional performance counters (retired_cnt, stall_cnt) are built when MCTL_PERF_EN is defined.
module mcycle_exec_ctl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    input  logic        do_branch,
    output logic [1:0]  aluop,
    output logic        alusrc,
    output logic        regdst,
    output logic        branch,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        memtoreg,
    output logic        illegal_op,
    output logic        mem_error,
    output logic        busy
`ifdef MCTL_PERF_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [1:0] {
        C_R,
        C_LW,
        C_SW,
        C_BEQ
    } cls_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_R;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        cnt_d      = '0;
        aluop      = 2'b00;
        alusrc     = 1'b0;
        regdst     = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        memtoreg   = 1'b0;
        illegal_op = 1'b0;
        mem_error  = 1'b0;
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                // mem_ready takes priority over a timeout landing in the same cycle
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_error = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    6'b000000: begin cls_d = C_R;   state_d = S_EXEC; end
                    6'b100011: begin cls_d = C_LW;  state_d = S_EXEC; end
                    6'b101011: begin cls_d = C_SW;  state_d = S_EXEC; end
                    6'b000100: begin cls_d = C_BEQ; state_d = S_EXEC; end
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        aluop   = 2'b10;
                        regdst  = 1'b1;
                        state_d = S_WB;
                    end
                    C_LW, C_SW: begin
                        alusrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    default: begin
                        aluop    = 2'b01;
                        branch   = 1'b1;
                        pc_src   = 1'b1;
                        pc_write = do_branch;
                        state_d  = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_read  = (cls_q == C_LW);
                mem_write = (cls_q == C_SW);
                if (mem_ready) begin
                    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
                end else if (cnt_q == CNT_LAST) begin
                    mem_error = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                if (cls_q == C_R) begin
                    regdst = 1'b1;
                end else begin
                    memtoreg = 1'b1;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef MCTL_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_q, stall_d;
    logic        retire, stall;

    // Only instructions that reach FETCH through their normal completion path are retired
    assign retire = (state_q == S_WB)
                 || (state_q == S_MEM  && mem_ready && cls_q == C_SW)
                 || (state_q == S_EXEC && cls_q == C_BEQ);
    assign stall  = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;

    assign retired_d = retire ? retired_q + 32'd1 : retired_q;
    assign stall_d   = stall  ? stall_q + 32'd1   : stall_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_mcycle_exec_ctl.sv
// Bench for mcycle_exec_ctl: per-instruction expected output traces built from the phase rules,
// replayed cycle by cycle with directed and randomized opcodes, memory latencies and branch flags.
module tb_mcycle_exec_ctl;

    localparam int T = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       do_branch = 1'b0;
    logic [1:0] aluop;
    logic       alusrc, regdst, branch, ir_write, pc_write, pc_src;
    logic       mem_read, mem_write, reg_write, memtoreg, illegal_op, mem_error, busy;
`ifdef MCTL_PERF_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    mcycle_exec_ctl #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .do_branch  (do_branch),
        .aluop      (aluop),
        .alusrc     (alusrc),
        .regdst     (regdst),
        .branch     (branch),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .memtoreg   (memtoreg),
        .illegal_op (illegal_op),
        .mem_error  (mem_error),
        .busy       (busy)
`ifdef MCTL_PERF_EN
        ,
        .retired_cnt(retired_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    logic [14:0] obs;
    assign obs = {aluop, alusrc, regdst, branch, ir_write, pc_write, pc_src,
                  mem_read, mem_write, reg_write, memtoreg, illegal_op, mem_error, busy};

    localparam logic [14:0] BUSY = 15'h0001, MERR = 15'h0002, ILL = 15'h0004, M2R = 15'h0008;
    localparam logic [14:0] RW   = 15'h0010, MW   = 15'h0020, MR  = 15'h0040, PCS = 15'h0080;
    localparam logic [14:0] PCW  = 15'h0100, IRW  = 15'h0200, BR  = 15'h0400, RD  = 15'h0800;
    localparam logic [14:0] AS   = 15'h1000, AOP_SUB = 15'h2000, AOP_R = 15'h4000;

    typedef struct {
        logic        rdy;
        logic [5:0]  op;
        logic        br;
        logic [14:0] exp;
        string       tag;
    } step_t;

    step_t trace[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    exp_retired = 0;
    int    exp_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef MCTL_PERF_EN
        check({tag, "_retired"}, retired_cnt, 32'(exp_retired));
        check({tag, "_stall"}, stall_cnt, 32'(exp_stall));
`endif
    endtask

    function automatic logic jbr();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] jop();
        return 6'($urandom);
    endfunction

    // 0=R, 1=LW, 2=SW, 3=BEQ, -1=unsupported
    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'b000000: return 0;
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000100: return 3;
            default:   return -1;
        endcase
    endfunction

    task automatic push(input logic rdy, input logic [5:0] op, input logic br,
                        input logic [14:0] e, input string tag);
        step_t s;
        s.rdy = rdy; s.op = op; s.br = br; s.exp = e; s.tag = tag;
        trace.push_back(s);
    endtask

    // Expected trace for one instruction starting in FETCH: fd/md are cycles of mem_ready low
    // in FETCH/MEM (md >= T means MEM never completes).
    task automatic build_instr(input logic [5:0] op, input int fd, input int md, input logic br);
        int c;
        logic [14:0] memop;
        c = cls_of(op);
        for (int i = 0; i < fd; i++)
            push(1'b0, jop(), jbr(), BUSY | MR | ((i % T == T - 1) ? MERR : 15'h0), "fetch_wait");
        exp_stall += fd;
        push(1'b1, jop(), jbr(), BUSY | MR | IRW | PCW, "fetch_done");
        if (c < 0) begin
            push(jbr(), op, jbr(), BUSY | ILL, "decode_illegal");
            return;
        end
        push(jbr(), op, jbr(), BUSY, "decode");
        case (c)
            0: begin
                push(jbr(), jop(), jbr(), BUSY | AOP_R | RD, "exec_r");
                push(jbr(), jop(), jbr(), BUSY | RW | RD, "wb_r");
                exp_retired++;
            end
            3: begin
                push(jbr(), jop(), br, BUSY | AOP_SUB | BR | PCS | (br ? PCW : 15'h0), "exec_beq");
                exp_retired++;
            end
            default: begin
                memop = (c == 1) ? MR : MW;
                push(jbr(), jop(), jbr(), BUSY | AS, "exec_mem");
                if (md >= T) begin
                    for (int i = 0; i < T; i++)
                        push(1'b0, jop(), jbr(), BUSY | memop | ((i == T - 1) ? MERR : 15'h0), "mem_timeout");
                    exp_stall += T;
                end else begin
                    for (int i = 0; i < md; i++)
                        push(1'b0, jop(), jbr(), BUSY | memop, "mem_wait");
                    exp_stall += md;
                    push(1'b1, jop(), jbr(), BUSY | memop, "mem_done");
                    if (c == 1) push(jbr(), jop(), jbr(), BUSY | RW | M2R, "wb_lw");
                    exp_retired++;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic run_trace(input int n);
        step_t s;
        int k;
        k = 0;
        while (trace.size() > 0 && (n < 0 || k < n)) begin
            s = trace.pop_front();
            mem_ready = s.rdy;
            opcode    = s.op;
            do_branch = s.br;
            #1;
            check(s.tag, 32'(obs), 32'(s.exp));
            tick();
            k++;
        end
    endtask

    function automatic int rand_delay();
        if ($urandom_range(0, 6) == 0) return int'($urandom_range(T - 1, 2 * T + 1));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [5:0] op;
        int sel;

        repeat (3) @(posedge clock);
        #2;
        mem_ready = 1'b1; opcode = 6'b100011; do_branch = 1'b1;
        #1;
        check("reset_outputs", 32'(obs), 32'h0);
        check_perf("reset");
        reset_n = 1'b1;
        #1;
        check("idle_after_reset", 32'(obs), 32'h0);
        tick();

        build_instr(6'b000000, 0, 0, 1'b0);  run_trace(-1);  check_perf("add");
        build_instr(6'b100011, 0, 3, 1'b0);  run_trace(-1);  check_perf("lw_wait3");
        build_instr(6'b000100, 0, 0, 1'b1);  run_trace(-1);
        build_instr(6'b000100, 0, 0, 1'b0);  run_trace(-1);  check_perf("beq");
        build_instr(6'b101011, 0, 99, 1'b0); run_trace(-1);  check_perf("sw_timeout");
        build_instr(6'b111111, 0, 0, 1'b0);  run_trace(-1);  check_perf("illegal");
        build_instr(6'b100011, T - 1, T - 1, 1'b0); run_trace(-1); check_perf("ready_at_limit");
        build_instr(6'b000000, T + 2, 0, 1'b0); run_trace(-1); check_perf("fetch_retry");

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1: op = 6'b000000;
                2, 3: op = 6'b100011;
                4, 5: op = 6'b101011;
                6, 7: op = 6'b000100;
                default: begin
                    op = jop();
                    while (cls_of(op) >= 0) op = jop();
                end
            endcase
            build_instr(op, rand_delay(), rand_delay(), jbr());
            run_trace(-1);
        end
        check_perf("random");

        // Abandon an lw in the middle of its MEM wait
        build_instr(6'b100011, 0, 5, 1'b0);
        run_trace(4);
        trace.delete();
        mem_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_reset", 32'(obs), 32'h0);
        exp_retired = 0;
        exp_stall = 0;
        check_perf("async_reset");
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("idle_after_reset2", 32'(obs), 32'h0);
        check_perf("after_release");
        tick();
        build_instr(6'b000000, 0, 0, 1'b0); run_trace(-1); check_perf("post_reset_add");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
